sum_decoder_serial: RTL and testbench

Bit-serial inverse of the 6-bit exact carry-lookahead adder. It recovers the operand A = Y − B from a 7-bit sum Y and the known operand B, one bit per clock, using a single borrow flip-flop. It sits downstream of the adder models in the approximate-arithmetic test harness and checks that an adder output is consistent with its operands. It also flags sums that no W-bit A could have produced.

---
 rtl/sum_decoder_serial_if.sv | 32 +++
 rtl/sum_decoder_serial.sv | 112 +++++++++++
 tb/tb_sum_decoder_serial.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sum_decoder_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : sum_decoder_serial_if
// Description : Handshake and data bundle for the bit-serial sum decoder.
//               The producer side (master) offers a sum/operand pair and
//               accepts the decoded result; the decoder is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface sum_decoder_serial_if #(
    parameter int W = 6
);
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   y;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   d;
    logic         borrow;
    logic         err;

    modport master (
        output in_valid, y, b, out_ready,
        input  in_ready, out_valid, d, borrow, err
    );

    modport slave (
        input  in_valid, y, b, out_ready,
        output in_ready, out_valid, d, borrow, err
    );
endinterface
`default_nettype wire

// File: rtl/sum_decoder_serial.sv
`default_nettype none
// ============================================================================
// Module      : sum_decoder_serial
// Description : Bit-serial subtractor recovering A = Y - B from a (W+1)-bit
//               sum and the W-bit operand B, one bit per clock through a
//               single borrow flop. Flags results that cannot be a W-bit A.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_decoder_serial #(
    parameter int W = 6
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    sum_decoder_serial_if.slave   bus
);
    localparam int            CW     = $clog2(W + 1);
    localparam logic [CW-1:0] c_LAST = CW'(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [W:0]     r_ysh;
    logic [W:0]     r_bsh;
    logic [W-1:0]   r_res;      // low W result bits collected so far, LSB-last
    logic [CW-1:0]  r_cnt;
    logic           r_br;
    logic [W:0]     r_d;
    logic           r_borrow;
    logic           r_err;
    logic           r_in_ready;
    logic           r_out_valid;

    logic           w_y0;
    logic           w_b0;
    logic           w_dbit;
    logic           w_br_nxt;

    // One full-subtractor slice on the current LSBs of the shift registers.
    assign w_y0     = r_ysh[0];
    assign w_b0     = r_bsh[0];
    assign w_dbit   = w_y0 ^ w_b0 ^ r_br;
    assign w_br_nxt = (~w_y0 & w_b0) | (~(w_y0 ^ w_b0) & r_br);

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.d         = r_d;
    assign bus.borrow    = r_borrow;
    assign bus.err       = r_err;

    // Control FSM and datapath; outputs are only updated on the final bit so
    // they stay frozen while a later operation is still shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ysh       <= '0;
            r_bsh       <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_br        <= 1'b0;
            r_d         <= '0;
            r_borrow    <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_ysh      <= bus.y;
                        r_bsh      <= {1'b0, bus.b};
                        r_br       <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_ysh <= r_ysh >> 1;
                    r_bsh <= r_bsh >> 1;
                    r_br  <= w_br_nxt;
                    r_res <= {w_dbit, r_res[W-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        // The bit produced now is d[W]; the rest sit in r_res.
                        r_d         <= {w_dbit, r_res};
                        r_borrow    <= w_br_nxt;
                        r_err       <= w_br_nxt | w_dbit;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sum_decoder_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_decoder_serial
// Description : Scoreboard bench for sum_decoder_serial. Stimulus pushes the
//               arithmetic expectation; a monitor pops on each retired result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_decoder_serial;
    localparam int W = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sum_decoder_serial_if #(.W(W)) bus ();

    sum_decoder_serial #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;
    int         rdy_mode = 2;   // 0 random, 1 forced low, 2 forced high

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction with wrap to W+1 bits.
    function automatic logic [8:0] model(input int y, input int b);
        int         diff;
        logic [6:0] dm;
        logic       br;
        logic       e;
        diff = y - b;
        dm   = 7'((diff + 128) % 128);
        br   = (y < b);
        e    = br || (diff >= 64);
        return {dm, br, e};
    endfunction

    // Consumer ready driver, offset from the main thread's sampling point.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.out_ready = ($urandom_range(0, 2) != 0);
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'b1;
        endcase
    end

    // Monitor: a result retires on the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got d=%0d with empty scoreboard", bus.d);
            end else begin
                mon_e = exp_q.pop_front();
                chk("d",      32'(bus.d),      32'(mon_e[8:2]));
                chk("borrow", 32'(bus.borrow), 32'(mon_e[1]));
                chk("err",    32'(bus.err),    32'(mon_e[0]));
            end
        end
    end

    // Offer one pair; returns at the accepting edge + 1.
    task automatic send(input int y, input int b, input bit push);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 60) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: in_ready=%0b, required 1", bus.in_ready);
                return;
            end
        end
        bus.in_valid = 1'b1;
        bus.y        = 7'(y);
        bus.b        = 6'(b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.y        = 7'($urandom);
        bus.b        = 6'($urandom);
        if (push) exp_q.push_back(model(y, b));
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d, required 0", exp_q.size());
        end
    endtask

    logic [6:0] snap_d;
    logic       snap_br;
    logic       snap_err;

    initial begin
        int g;
        int a;
        int yv;
        int bv;
        bus.in_valid = 1'b0;
        bus.y        = '0;
        bus.b        = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_d",         32'(bus.d),         0);
        chk("rst_borrow",    32'(bus.borrow),    0);
        chk("rst_err",       32'(bus.err),       0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: out_valid appears after edge E0+W+1.
        send(45, 20, 1);
        chk("in_ready_after_accept", 32'(bus.in_ready), 0);
        for (int k = 1; k <= W + 1; k++) begin
            @(posedge clk); #1;
            chk("latency_out_valid", 32'(bus.out_valid), (k == W + 1) ? 1 : 0);
        end
        @(posedge clk); #1;
        chk("in_ready_after_retire", 32'(bus.in_ready), 1);
        chk("out_valid_after_retire", 32'(bus.out_valid), 0);

        // Directed corner values.
        send(126, 63, 1);
        send(0, 0, 1);
        send(5, 9, 1);
        send(100, 0, 1);
        wait_drain();

        // Back-pressure: DONE holds, in_valid ignored.
        rdy_mode = 1;
        send(77, 13, 1);
        g = 0;
        while (bus.out_valid !== 1'b1 && g < 30) begin
            @(posedge clk); #1;
            g++;
        end
        chk("bp_out_valid_seen", 32'(bus.out_valid), 1);
        snap_d   = bus.d;
        snap_br  = bus.borrow;
        snap_err = bus.err;
        chk("bp_d_value", 32'(snap_d), 64);
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.y        = 7'($urandom);
            bus.b        = 6'($urandom);
            @(posedge clk); #1;
            chk("bp_d_hold",      32'(bus.d),         32'(snap_d));
            chk("bp_borrow_hold", 32'(bus.borrow),    32'(snap_br));
            chk("bp_err_hold",    32'(bus.err),       32'(snap_err));
            chk("bp_out_valid",   32'(bus.out_valid), 1);
            chk("bp_in_ready",    32'(bus.in_ready),  0);
        end
        bus.in_valid = 1'b0;
        rdy_mode     = 2;
        @(posedge clk); #1;
        chk("bp_in_ready_release", 32'(bus.in_ready), 1);
        wait_drain();

        // Reset during the third CALC cycle.
        send(50, 7, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  32'(bus.in_ready),  1);
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_d",         32'(bus.d),         0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(10, 3, 1);
        wait_drain();

        // Random sweep with random gaps on both sides.
        rdy_mode = 0;
        for (int i = 0; i < 600; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            bv = int'($urandom_range(0, 63));
            if (i % 2 == 0) begin
                a  = int'($urandom_range(0, 63));
                yv = a + bv;
            end else begin
                yv = int'($urandom_range(0, 127));
            end
            send(yv, bv, 1);
        end
        wait_drain();
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        #1;
        chk("final_idle_in_ready", 32'(bus.in_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
